// File: rtl/common_pkg.sv
// Types shared between the display-list player and the rasterizer: the command
// encoding and the packed layout of one display-list memory word.
package common;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_PIXEL     = 3'd1,
        CMD_LINE      = 3'd2,
        CMD_RECT      = 3'd3,
        CMD_FILL_RECT = 3'd4,
        CMD_CLEAR     = 3'd5
    } raster_command_t;

    // One list word, MSB first: last flag, command, two corner points, colour.
    typedef struct packed {
        logic            last;
        raster_command_t command;
        logic [7:0]      x0;
        logic [7:0]      y0;
        logic [7:0]      x1;
        logic [7:0]      y1;
        logic [2:0]      colour;
    } dl_word_t;

endpackage

// File: rtl/display_list_player.sv
// Walks a display list in external memory and hands each command to the
// rasterizer, optionally replaying the list once per video frame.
module display_list_player
    import common::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        loop_en,
    input  logic                        frame_start,
    input  logic [ADDR_W-1:0]           list_base,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [$bits(dl_word_t)-1:0] mem_data,
    output raster_command_t             command,
    output logic [7:0]                  x0,
    output logic [7:0]                  y0,
    output logic [7:0]                  x1,
    output logic [7:0]                  y1,
    output logic [2:0]                  colour,
    output logic                        execute_request,
    input  logic                        gpu_busy,
    output logic                        dl_busy,
    output logic                        dl_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FRAME_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    dl_word_t          ops_q, ops_d;
    logic              abort_pend_q, abort_pend_d;

    dl_word_t mem_word;
    logic     cmd_done;
    logic     abort_hit;
    logic     start_ok;

    assign mem_word  = dl_word_t'(mem_data);
    assign cmd_done  = (state_q == S_WAIT_DONE) && !gpu_busy;
    assign abort_hit = abort || abort_pend_q;
    assign start_ok  = (state_q == S_IDLE) && start && !abort;

    // State and datapath registers. Memory data is registered in the operand
    // register, so clearing it on reset is cheap and keeps outputs clean.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before this edge.
        if (!n_rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            addr_q       <= '0;
            ops_q        <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
            ops_q        <= ops_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (start_ok) state_d = S_FETCH;
            S_FETCH:      state_d = abort ? S_IDLE : S_LATCH;
            S_LATCH:      state_d = abort ? S_IDLE : S_ISSUE;
            S_ISSUE: begin
                if (abort)          state_d = S_IDLE;
                else if (!gpu_busy) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK:   if (gpu_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!gpu_busy) begin
                    if (abort_hit)       state_d = S_IDLE;
                    else if (!ops_q.last) state_d = S_FETCH;
                    else if (loop_en)    state_d = S_FRAME_WAIT;
                    else                 state_d = S_IDLE;
                end
            end
            S_FRAME_WAIT: begin
                if (abort || !loop_en) state_d = S_IDLE;
                else if (frame_start)  state_d = S_FETCH;
            end
            default:      state_d = S_IDLE;
        endcase
    end

    // Address, operand and pending-abort registers. The address register is
    // loaded on the way into FETCH so the read is already presented in FETCH.
    always_comb begin
        base_d       = base_q;
        addr_d       = addr_q;
        ops_d        = ops_q;
        abort_pend_d = abort_pend_q;

        if (start_ok) begin
            base_d = list_base;
            addr_d = list_base;
        end

        if (state_q == S_LATCH) ops_d = mem_word;

        if ((state_q == S_WAIT_ACK || state_q == S_WAIT_DONE) && abort)
            abort_pend_d = 1'b1;

        if (cmd_done) begin
            abort_pend_d = 1'b0;
            if (!abort_hit && !ops_q.last) addr_d = addr_q + ADDR_W'(1);
        end

        if (state_q == S_FRAME_WAIT && loop_en && frame_start && !abort)
            addr_d = base_q;
    end

    // Outputs. An abort arriving in ISSUE suppresses the request in that cycle.
    always_comb begin
        execute_request = (state_q == S_ISSUE) && !gpu_busy && !abort;
        dl_done         = cmd_done && ops_q.last && !abort_hit;
        dl_busy         = (state_q != S_IDLE);
    end

    assign mem_addr = addr_q;
    assign command  = ops_q.command;
    assign x0       = ops_q.x0;
    assign y0       = ops_q.y0;
    assign x1       = ops_q.x1;
    assign y1       = ops_q.y1;
    assign colour   = ops_q.colour;

endmodule

// File: tb/tb_display_list_player.sv
// Scoreboard bench: a list-walking reference model queues the expected command
// and end-of-list events; a monitor pops them as the player emits them.
module tb_display_list_player;
    import common::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WW     = $bits(dl_word_t);

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              loop_en = 1'b0;
    logic              frame_start = 1'b0;
    logic [ADDR_W-1:0] list_base = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [WW-1:0]     mem_data;
    raster_command_t   command;
    logic [7:0]        x0, y0, x1, y1;
    logic [2:0]        colour;
    logic              execute_request;
    logic              gpu_busy;
    logic              dl_busy, dl_done;

    logic rast_busy = 1'b0;
    logic hold_busy = 1'b0;
    int   rast_lat  = 0;
    int   busy_len  = 4;
    assign gpu_busy = rast_busy | hold_busy;

    display_list_player #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .loop_en(loop_en), .frame_start(frame_start), .list_base(list_base),
        .mem_addr(mem_addr), .mem_data(mem_data), .command(command),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour(colour),
        .execute_request(execute_request), .gpu_busy(gpu_busy),
        .dl_busy(dl_busy), .dl_done(dl_done)
    );

    always #10 clk = ~clk;

    // Synchronous-read list memory: data follows the address by one cycle.
    logic [WW-1:0] mem [DEPTH];
    always @(posedge clk) mem_data <= mem[mem_addr];

    typedef struct {
        bit            done;
        logic [WW-1:0] word;
    } ev_t;
    ev_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [WW-2:0] ops;
    logic [WW-1:0] last_word = '0;
    assign ops = {command, x0, y0, x1, y1, colour};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every request or end-of-list pulse must match the queue head.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (execute_request === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].done)
                    check("unexpected_req", 64'(execute_request), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    check("operands", 64'(ops), 64'(e.word[WW-2:0]));
                    last_word = e.word;
                end
            end
            if (dl_done === 1'b1) begin
                if (exp_q.size() == 0 || !exp_q[0].done)
                    check("unexpected_done", 64'(dl_done), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    check("done_operands_stable", 64'(ops), 64'(last_word[WW-2:0]));
                end
            end
        end
    end

    // Rasterizer model: after a request, optional delay, then busy for busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (execute_request === 1'b1) begin
                repeat (rast_lat) @(posedge clk);
                @(posedge clk);
                #1 rast_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 rast_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_list(input int base, input int len);
        dl_word_t w;
        for (int i = 0; i < len; i++) begin
            w.last    = (i == len - 1);
            w.command = raster_command_t'($urandom_range(0, 5));
            w.x0      = 8'($urandom);
            w.y0      = 8'($urandom);
            w.x1      = 8'($urandom);
            w.y1      = 8'($urandom);
            w.colour  = 3'($urandom);
            mem[(base + i) % DEPTH] = w;
        end
    endtask

    // Reference model: walk from base, wrapping, until a word with the last flag.
    task automatic expect_list(input int base, input bit with_done);
        ev_t e;
        int  a = base;
        for (int n = 0; n < DEPTH; n++) begin
            e.done = 1'b0;
            e.word = mem[a];
            exp_q.push_back(e);
            if (mem[a][WW-1]) break;
            a = (a + 1) % DEPTH;
        end
        if (with_done) begin
            e.done = 1'b1;
            e.word = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_first_only(input int base);
        ev_t e;
        e.done = 1'b0;
        e.word = mem[base];
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int base);
        list_base = ADDR_W'(base);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && dl_busy !== 1'b0; i++) @(negedge clk);
        check(name, 64'(dl_busy), 64'(0));
        tick();
        while (rast_busy) tick();
        tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget && dl_done !== 1'b1; i++) @(negedge clk);
        check(name, 64'(i < budget), 64'(1));
        tick();
    endtask

    task automatic drained(input string name);
        check(name, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int cnt;

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_operands", 64'(ops), 64'(0));
        check("rst_exec", 64'(execute_request), 64'(0));
        check("rst_done", 64'(dl_done), 64'(0));
        check("rst_busy", 64'(dl_busy), 64'(0));
        tick();
        n_rst = 1'b1;
        tick();

        // Three-word list at base 5, with start-to-request latency.
        busy_len = 4;
        rast_lat = 0;
        load_list(5, 3);
        expect_list(5, 1'b1);
        pulse_start(5);
        @(negedge clk);
        check("lat_fetch_no_req", 64'(execute_request), 64'(0));
        check("lat_fetch_addr", 64'(mem_addr), 64'(5));
        check("busy_after_start", 64'(dl_busy), 64'(1));
        @(negedge clk);
        check("lat_latch_no_req", 64'(execute_request), 64'(0));
        @(negedge clk);
        check("lat_issue_req", 64'(execute_request), 64'(1));
        wait_idle("list3_idle", 200);
        drained("list3_drained");

        // Rasterizer busy while the first command waits to issue.
        load_list(300, 1);
        expect_list(300, 1'b1);
        hold_busy = 1'b1;
        pulse_start(300);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (execute_request === 1'b1) cnt++;
        end
        check("held_busy_no_req", 64'(cnt), 64'(0));
        check("held_busy_still_busy", 64'(dl_busy), 64'(1));
        tick();
        hold_busy = 1'b0;
        wait_idle("held_busy_idle", 100);
        drained("held_busy_drained");

        // Address wrap from the top of memory.
        load_list(DEPTH - 1, 2);
        expect_list(DEPTH - 1, 1'b1);
        pulse_start(DEPTH - 1);
        wait_idle("wrap_idle", 100);
        drained("wrap_drained");

        // Looping one-word list, replayed once per frame; stray frame pulses ignored.
        loop_en = 1'b1;
        load_list(40, 1);
        expect_list(40, 1'b1);
        pulse_start(40);
        wait_done("loop_first_done", 100);
        for (int f = 0; f < 2; f++) begin
            repeat (8) tick();
            check("loop_frame_wait_busy", 64'(dl_busy), 64'(1));
            drained("loop_no_early_req");
            expect_list(40, 1'b1);
            pulse_frame();
            tick();
            pulse_frame();
            wait_done("loop_replay_done", 100);
        end
        repeat (8) tick();
        drained("loop_no_queued_frame");
        loop_en = 1'b0;
        tick();
        tick();
        check("loop_off_idle", 64'(dl_busy), 64'(0));

        // Abort while a command is in flight.
        busy_len = 6;
        load_list(200, 3);
        expect_first_only(200);
        pulse_start(200);
        cnt = 0;
        while (rast_busy !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("abort_saw_busy", 64'(cnt < 100), 64'(1));
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle("abort_idle", 100);
        repeat (10) tick();
        drained("abort_drained");

        // Abort and start together in IDLE.
        load_list(50, 1);
        abort = 1'b1;
        pulse_start(50);
        abort = 1'b0;
        @(negedge clk);
        check("abort_start_idle", 64'(dl_busy), 64'(0));
        repeat (10) tick();

        // Reset while waiting for the rasterizer to acknowledge.
        rast_lat = 6;
        busy_len = 4;
        load_list(100, 3);
        expect_first_only(100);
        pulse_start(100);
        cnt = 0;
        while (execute_request !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_saw_req", 64'(cnt < 100), 64'(1));
        tick();
        n_rst = 1'b0;
        tick();
        @(negedge clk);
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check("midrst_operands", 64'(ops), 64'(0));
        check("midrst_exec", 64'(execute_request), 64'(0));
        check("midrst_busy", 64'(dl_busy), 64'(0));
        tick();
        n_rst = 1'b1;
        repeat (20) tick();
        drained("midrst_drained");

        // Randomized lists, base, and rasterizer timing.
        for (int it = 0; it < 10; it++) begin
            int base;
            base     = $urandom_range(0, DEPTH - 1);
            rast_lat = $urandom_range(0, 3);
            busy_len = $urandom_range(1, 6);
            load_list(base, $urandom_range(1, 5));
            expect_list(base, 1'b1);
            pulse_start(base);
            wait_idle("rand_idle", 400);
            drained("rand_drained");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
